// File: rtl/cordic_pkg.sv
// Purpose: shared types and defaults for the CORDIC datapath blocks.
// Contents: default operand/slice widths, FSM state encoding, and the
//           signed-overflow rule for subtraction.
package cordic_pkg;

    localparam int unsigned WIDTH_DEFAULT   = 32;
    localparam int unsigned SLICE_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Signed overflow of a - b: operand signs differ and the result sign
    // disagrees with the minuend.
    function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic d_msb);
        return (a_msb != b_msb) && (d_msb != a_msb);
    endfunction

endpackage

// File: rtl/sub_slice.sv
// Purpose: combinational SLICE_W-bit subtractor with borrow, d = a - b - bin.
// Ports:
//   a, b  in   SLICE_W  minuend / subtrahend slice
//   bin   in   1        borrow from the previous (lower) slice
//   d     out  SLICE_W  slice difference
//   bout  out  1        borrow into the next (higher) slice
module sub_slice #(
    parameter int unsigned SLICE_W = 8
) (
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               bin,
    output logic [SLICE_W-1:0] d,
    output logic               bout
);

    localparam int unsigned EXT_W = SLICE_W + 1;

    logic [EXT_W-1:0] ext_c;

    // Zero-extended subtraction; the extra top bit is the outgoing borrow.
    assign ext_c = {1'b0, a} - {1'b0, b} - EXT_W'(bin);
    assign d     = ext_c[SLICE_W-1:0];
    assign bout  = ext_c[SLICE_W];

endmodule

// File: rtl/subtractor_32b_seq.sv
// Purpose: multi-cycle subtractor, diff = a - b - bin, one SLICE_W-bit slice
//          per cycle (LSB first) with the borrow rippled between cycles.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid / in_ready   operand handshake (a, b, bin)
//   out_valid / out_ready result handshake (diff, bout, ovf)
//   diff                  a - b - bin modulo 2^WIDTH
//   bout                  1 iff unsigned a < b + bin
//   ovf                   signed overflow of the subtraction
module subtractor_32b_seq
    import cordic_pkg::*;
#(
    parameter int unsigned WIDTH   = WIDTH_DEFAULT,
    parameter int unsigned SLICE_W = SLICE_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int unsigned SLICES = WIDTH / SLICE_W;
    localparam int unsigned CNT_W  = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam int unsigned IDX_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_e             state_q,     state_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic [WIDTH-1:0]   a_q,         a_d;
    logic [WIDTH-1:0]   b_q,         b_d;
    logic               borrow_q,    borrow_d;
    logic [WIDTH-1:0]   diff_q,      diff_d;
    logic               bout_q,      bout_d;
    logic               ovf_q,       ovf_d;
    logic               in_ready_q,  in_ready_d;
    logic               out_valid_q, out_valid_d;

    logic [IDX_W-1:0]   lsb_c;
    logic [SLICE_W-1:0] slice_diff_c;
    logic               slice_bout_c;

    // Bit offset of the slice being worked on this cycle.
    assign lsb_c = IDX_W'(cnt_q) * IDX_W'(SLICE_W);

    // Single shared slice subtractor, steered by the slice counter.
    sub_slice #(
        .SLICE_W (SLICE_W)
    ) u_slice (
        .a    (a_q[lsb_c +: SLICE_W]),
        .b    (b_q[lsb_c +: SLICE_W]),
        .bin  (borrow_q),
        .d    (slice_diff_c),
        .bout (slice_bout_c)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        borrow_d = borrow_q;
        diff_d   = diff_q;
        bout_d   = bout_q;
        ovf_d    = ovf_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d      = a;
                    b_d      = b;
                    borrow_d = bin;
                    cnt_d    = '0;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                diff_d[lsb_c +: SLICE_W] = slice_diff_c;
                borrow_d = slice_bout_c;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(SLICES - 1)) begin
                    bout_d  = slice_bout_c;
                    ovf_d   = sub_ovf(a_q[WIDTH-1], b_q[WIDTH-1], slice_diff_c[SLICE_W-1]);
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            borrow_q    <= 1'b0;
            diff_q      <= '0;
            bout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            borrow_q    <= borrow_d;
            diff_q      <= diff_d;
            bout_q      <= bout_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign bout      = bout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_subtractor_32b_seq.sv
// Purpose: self-checking bench for subtractor_32b_seq: directed cases,
//          randomized operands against a plain-arithmetic reference model,
//          output stalls and reset in the middle of an operation.
module tb_subtractor_32b_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] diff;
    logic        bout;
    logic        ovf;

    int errors = 0;
    int checks = 0;

    subtractor_32b_seq #(
        .WIDTH   (32),
        .SLICE_W (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: integer arithmetic on the full operand values.
    task automatic model(input logic [31:0] ma, input logic [31:0] mb, input logic mbin,
                         output logic [31:0] md, output logic mbo, output logic mov);
        longint unsigned ua, ub, ur;
        longint          sa, sb, sr;
        ua  = longint'(ma);
        ub  = longint'(mb);
        ur  = ua - ub - longint'(mbin);
        md  = ur[31:0];
        mbo = (ua < ub + longint'(mbin));
        sa  = longint'($signed(ma));
        sb  = longint'($signed(mb));
        sr  = sa - sb - longint'(mbin);
        mov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    endtask

    // One full operation: accept, latency, result, optional stall, handshake.
    task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_,
                          input logic tbin, input logic [31:0] ed, input logic ebo,
                          input logic eov, input int stall);
        int lat;
        @(negedge clk);
        chk({tag, ".in_ready_idle"}, 32'(in_ready), 32'd1);
        a = ta; b = tb_; bin = tbin; in_valid = 1'b1;
        @(posedge clk); #1;
        // Keep junk on the inputs with in_valid high: must be ignored.
        a = $urandom; b = $urandom; bin = 1'($urandom);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            if (lat < 4) chk({tag, ".in_ready_busy"}, 32'(in_ready), 32'd0);
        end while (!out_valid && lat < 20);
        chk({tag, ".latency"}, 32'(lat), 32'd4);
        chk({tag, ".diff"}, diff, ed);
        chk({tag, ".bout"}, 32'(bout), 32'(ebo));
        chk({tag, ".ovf"}, 32'(ovf), 32'(eov));
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            a = $urandom; b = $urandom; in_valid = 1'($urandom);
            @(posedge clk); #1;
            chk({tag, ".stall_valid"}, 32'(out_valid), 32'd1);
            chk({tag, ".stall_ready"}, 32'(in_ready), 32'd0);
            chk({tag, ".stall_diff"}, diff, ed);
            chk({tag, ".stall_flags"}, {30'd0, bout, ovf}, {30'd0, ebo, eov});
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, ".valid_drop"}, 32'(out_valid), 32'd0);
        chk({tag, ".ready_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] ra, rb, md;
        logic        rbin, mbo, mov;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; bin = 1'b0;
        #12;
        chk("reset.in_ready", 32'(in_ready), 32'd1);
        chk("reset.out_valid", 32'(out_valid), 32'd0);
        chk("reset.diff", diff, 32'd0);
        chk("reset.flags", {30'd0, bout, ovf}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases with hand-computed results.
        run_op("t1", 32'h00000003, 32'h00000001, 1'b0, 32'h00000002, 1'b0, 1'b0, 0);
        run_op("t2", 32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 0);
        run_op("t3", 32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1, 0);
        run_op("t4a", 32'h12345678, 32'h12345678, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 0);
        run_op("t4b", 32'h0000000F, 32'h00000001, 1'b1, 32'h0000000D, 1'b0, 1'b0, 0);
        run_op("zero", 32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0, 0);
        run_op("t5", 32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h80000000, 1'b1, 1'b1, 5);

        // Randomized operands against the reference model.
        for (int i = 0; i < 24; i++) begin
            ra = $urandom; rb = $urandom; rbin = 1'($urandom);
            if (i % 6 == 0) rb = ra;
            model(ra, rb, rbin, md, mbo, mov);
            run_op("rand", ra, rb, rbin, md, mbo, mov, i % 3);
        end

        // Reset while BUSY on slice 2.
        @(negedge clk);
        a = 32'hDEADBEEF; b = 32'h01234567; bin = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("t6.pre_diff_nonzero", 32'(diff != 32'd0), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("t6.out_valid", 32'(out_valid), 32'd0);
        chk("t6.diff", diff, 32'd0);
        chk("t6.in_ready", 32'(in_ready), 32'd1);
        chk("t6.flags", {30'd0, bout, ovf}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("t6post", 32'h00000010, 32'hFFFFFFF0, 1'b0, 32'h00000020, 1'b1, 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
